// File: rtl/dlfloat_mult_pipe.sv
// -----------------------------------------------------------------------------
// dlfloat_mult_pipe
//
// Pipelined floating-point multiplier for DLfloat-style formats (default
// DLfloat16: 1 sign, 6 exponent, 9 mantissa bits, bias 31). No denormals:
// an exponent field of 0 is zero, and the all-ones magnitude is NaN.
// Rounding is round-to-nearest-even, overflow saturates to max finite and
// underflow flushes to +0.
//
// Pipeline ranks (one result per cycle, a/b accepted at edge N -> c at N+3):
//   in  : operand capture
//   s1  : unpack, special detect, exponent sum, mantissa product
//   s2  : normalise, round
//   out : classify, pack, flags
// Backpressure is a global stall: every rank holds while in_ready is low.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b present
//   in_ready   block accepts a/b this cycle
//   a, b       operands {sign, exp, mant}
//   out_valid  c/flags valid
//   out_ready  downstream accepts c this cycle
//   c          product
//   flags      {nan, overflow, underflow, inexact}, aligned with c
// -----------------------------------------------------------------------------
module dlfloat_mult_pipe #(
    parameter int  EXP_W = 6,
    parameter int  MAN_W = 9,
    parameter int  BIAS  = 31,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic [3:0]   flags
);

    // Signed exponent width: headroom for ea+eb and the two possible +1 steps.
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * (MAN_W + 1);

    localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
    localparam logic signed [EW-1:0] ONE_S     = EW'(32'sd1);
    localparam logic signed [EW-1:0] ZERO_S    = EW'(32'sd0);
    localparam logic signed [EW-1:0] EXP_MAX_S = EW'((32'sd1 << EXP_W) - 32'sd1);

    // Magnitude field all ones encodes NaN regardless of sign.
    function automatic logic is_nan(input logic [W-2:0] mag);
        return &mag;
    endfunction

    // Exponent field zero encodes zero; the mantissa is ignored.
    function automatic logic is_zero(input logic [EXP_W-1:0] exp_f);
        return (exp_f == {EXP_W{1'b0}});
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                 in_valid_r;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;

    logic                 s1_valid_r;
    logic                 s1_sign_r;
    logic                 s1_nan_r;
    logic                 s1_zero_r;
    logic signed [EW-1:0] s1_exp_r;
    logic [PW-1:0]        s1_prod_r;

    logic                 s2_valid_r;
    logic                 s2_sign_r;
    logic                 s2_nan_r;
    logic                 s2_zero_r;
    logic signed [EW-1:0] s2_exp_r;
    logic [MAN_W-1:0]     s2_mant_r;
    logic                 s2_inexact_r;

    logic                 out_valid_r;
    logic [W-1:0]         c_r;
    logic [3:0]           flags_r;

    logic                 adv_s;

    // Global stall: the whole pipe moves only when the output slot frees up.
    assign adv_s     = ~rst & (out_ready | ~out_valid_r);
    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign flags     = flags_r;

    // ------------------------------------------------------------------------
    // Stage 1 combinational: unpack, specials, exponent sum, product
    // ------------------------------------------------------------------------
    logic                 s1_sign_s;
    logic                 s1_nan_s;
    logic                 s1_zero_s;
    logic signed [EW-1:0] s1_exp_s;
    logic [PW-1:0]        s1_prod_s;

    // Unpack operands and form exponent sum and full-width mantissa product.
    always_comb begin
        s1_sign_s = a_r[W-1] ^ b_r[W-1];
        s1_nan_s  = is_nan(a_r[W-2:0]) | is_nan(b_r[W-2:0]);
        s1_zero_s = is_zero(a_r[W-2:MAN_W]) | is_zero(b_r[W-2:MAN_W]);
        s1_exp_s  = $signed({2'b00, a_r[W-2:MAN_W]})
                  + $signed({2'b00, b_r[W-2:MAN_W]}) - BIAS_S;
        s1_prod_s = PW'({1'b1, a_r[MAN_W-1:0]}) * PW'({1'b1, b_r[MAN_W-1:0]});
    end

    // ------------------------------------------------------------------------
    // Stage 2 combinational: normalise and round-to-nearest-even
    // ------------------------------------------------------------------------
    // prod_n_s drops the leading one so its MSB is the first stored mantissa bit.
    logic [PW-2:0]        prod_n_s;
    logic signed [EW-1:0] exp_n_s;
    logic [MAN_W-1:0]     mant_t_s;
    logic                 guard_s;
    logic                 sticky_s;
    logic                 round_up_s;
    logic [MAN_W:0]       mant_sum_s;
    logic signed [EW-1:0] s2_exp_s;
    logic                 s2_inexact_s;

    // Product lies in [1,4): shift by one when it reached 2, then round.
    always_comb begin
        prod_n_s     = s1_prod_r[PW-1] ? s1_prod_r[PW-2:0]
                                       : {s1_prod_r[PW-3:0], 1'b0};
        exp_n_s      = s1_exp_r + (s1_prod_r[PW-1] ? ONE_S : ZERO_S);
        mant_t_s     = prod_n_s[PW-2 -: MAN_W];
        guard_s      = prod_n_s[PW-2-MAN_W];
        sticky_s     = |prod_n_s[PW-3-MAN_W:0];
        round_up_s   = guard_s & (sticky_s | mant_t_s[0]);
        // A carry out leaves the low MAN_W bits at zero, which is the
        // renormalised mantissa; only the exponent needs the extra step.
        mant_sum_s   = {1'b0, mant_t_s} + {{MAN_W{1'b0}}, round_up_s};
        s2_exp_s     = exp_n_s + (mant_sum_s[MAN_W] ? ONE_S : ZERO_S);
        s2_inexact_s = guard_s | sticky_s;
    end

    // ------------------------------------------------------------------------
    // Stage 3 combinational: classify and pack
    // ------------------------------------------------------------------------
    logic [W-1:0] c_s;
    logic [3:0]   flags_s;

    // Priority: NaN, zero operand, underflow, overflow, normal result.
    always_comb begin
        c_s     = {W{1'b0}};
        flags_s = 4'b0000;
        if (s2_nan_r) begin
            c_s     = {1'b0, {(W-1){1'b1}}};
            flags_s = 4'b1000;
        end else if (s2_zero_r) begin
            c_s     = {W{1'b0}};
            flags_s = 4'b0000;
        end else if (s2_exp_r <= ZERO_S) begin
            c_s     = {W{1'b0}};
            flags_s = 4'b0011;
        end else if ((s2_exp_r > EXP_MAX_S) ||
                     ((s2_exp_r == EXP_MAX_S) && (&s2_mant_r))) begin
            // Top exponent with all-ones mantissa would alias NaN: saturate.
            c_s     = {s2_sign_r, {EXP_W{1'b1}}, {(MAN_W-1){1'b1}}, 1'b0};
            flags_s = 4'b0101;
        end else begin
            c_s     = {s2_sign_r, s2_exp_r[EXP_W-1:0], s2_mant_r};
            flags_s = {3'b000, s2_inexact_r};
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Operand capture rank; a/b load only on an actual input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_r <= 1'b0;
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
        end else if (adv_s) begin
            in_valid_r <= in_valid;
            if (in_valid) begin
                a_r <= a;
                b_r <= b;
            end
        end
    end

    // Stage 1 rank: unpacked operands, exponent sum and product.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_nan_r   <= 1'b0;
            s1_zero_r  <= 1'b0;
            s1_exp_r   <= ZERO_S;
            s1_prod_r  <= {PW{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= in_valid_r;
            s1_sign_r  <= s1_sign_s;
            s1_nan_r   <= s1_nan_s;
            s1_zero_r  <= s1_zero_s;
            s1_exp_r   <= s1_exp_s;
            s1_prod_r  <= s1_prod_s;
        end
    end

    // Stage 2 rank: normalised, rounded mantissa and final exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r   <= 1'b0;
            s2_sign_r    <= 1'b0;
            s2_nan_r     <= 1'b0;
            s2_zero_r    <= 1'b0;
            s2_exp_r     <= ZERO_S;
            s2_mant_r    <= {MAN_W{1'b0}};
            s2_inexact_r <= 1'b0;
        end else if (adv_s) begin
            s2_valid_r   <= s1_valid_r;
            s2_sign_r    <= s1_sign_r;
            s2_nan_r     <= s1_nan_r;
            s2_zero_r    <= s1_zero_r;
            s2_exp_r     <= s2_exp_s;
            s2_mant_r    <= mant_sum_s[MAN_W-1:0];
            s2_inexact_r <= s2_inexact_s;
        end
    end

    // Output rank: packed result and flags, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            c_r         <= {W{1'b0}};
            flags_r     <= 4'b0000;
        end else if (adv_s) begin
            out_valid_r <= s2_valid_r;
            c_r         <= c_s;
            flags_r     <= flags_s;
        end
    end

endmodule

// File: tb/tb_dlfloat_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_dlfloat_mult_pipe
//
// Scoreboard bench for dlfloat_mult_pipe. The driver pushes the hand-computed
// result of every accepted operand pair into a queue; independent monitors pop
// and compare whenever a DUT presents a result. Two instances: default
// DLfloat16 and a bfloat16-like layout (EXP_W=8, MAN_W=7, BIAS=127).
// -----------------------------------------------------------------------------
module tb_dlfloat_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, c;
    logic [3:0]  flags;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [15:0] a2, b2, c2;
    logic [3:0]  flags2;

    dlfloat_mult_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .flags(flags)
    );

    dlfloat_mult_pipe #(.EXP_W(8), .MAN_W(7), .BIAS(127)) dut_bf (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .out_valid(out_valid2), .out_ready(out_ready2), .c(c2), .flags(flags2)
    );

    typedef struct {
        logic [15:0] c;
        logic [3:0]  f;
        int          acc;   // edge number at which the operands were taken
        bit          lat;   // check 3-cycle latency (out_ready held high)
    } exp_t;

    exp_t sb_q[$];
    exp_t sb2_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Directed vectors, expected results worked out by hand (DLfloat16).
    // flags = {nan, overflow, underflow, inexact}
    logic [15:0] va [9] = '{16'h3E00, 16'h3F00, 16'hC000, 16'h3E01, 16'h3E01,
                            16'h7FFE, 16'h0200, 16'h7FFF, 16'h0000};
    logic [15:0] vb [9] = '{16'h3E00, 16'h3F00, 16'h4100, 16'h3E01, 16'h3F00,
                            16'h7FFE, 16'h0200, 16'h0000, 16'hC300};
    logic [15:0] vc [9] = '{16'h3E00, 16'h4040, 16'hC300, 16'h3E02, 16'h3F02,
                            16'h7FFE, 16'h0000, 16'h7FFF, 16'h0000};
    logic [3:0]  vf [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                            4'b0101, 4'b0011, 4'b1000, 4'b0000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Present one operand pair to instance sel until it is accepted.
    task automatic issue(input int sel, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] ec, input logic [3:0] ef,
                         input bit lat, input bit rnd);
        exp_t e;
        int   n;
        bit   done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel == 0) begin
                a = ia; b = ib; in_valid = 1'b1; in_valid2 = 1'b0;
            end else begin
                a2 = ia; b2 = ib; in_valid2 = 1'b1; in_valid = 1'b0;
            end
            #1;
            if ((sel == 0 && in_ready) || (sel != 0 && in_ready2)) begin
                e.c = ec; e.f = ef; e.acc = cyc + 1; e.lat = lat;
                if (sel == 0) sb_q.push_back(e);
                else          sb2_q.push_back(e);
                done = 1'b1;
            end else if (n >= 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_timeout: operands %h x %h never accepted", ia, ib);
                done = 1'b1;
            end
            n++;
        end
    endtask

    // Idle inputs until both scoreboards empty (bounded), then confirm.
    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || sb2_q.size() != 0) && n < 300) begin
            @(negedge clk);
            in_valid = 1'b0; in_valid2 = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        end
        #3;
        check("drain_empty", 32'(sb_q.size() + sb2_q.size()), 32'd0);
    endtask

    // Monitor for the default instance: scoreboard, hold stability, in_ready.
    initial begin
        exp_t        e;
        logic [15:0] held_c;
        logic [3:0]  held_f;
        bit          holding;
        holding = 1'b0;
        held_c  = 16'h0000;
        held_f  = 4'b0000;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                holding = 1'b0;
            end else begin
                check("in_ready", 32'(in_ready), 32'(out_ready | !out_valid));
                if (holding) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_c", 32'(c), 32'(held_c));
                    check("hold_flags", 32'(flags), 32'(held_f));
                end
                if (out_valid && out_ready) begin
                    holding = 1'b0;
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got c=%h flags=%b, expected none", c, flags);
                    end else begin
                        e = sb_q.pop_front();
                        check("result_c", 32'(c), 32'(e.c));
                        check("result_flags", 32'(flags), 32'(e.f));
                        if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
                    end
                end else if (out_valid) begin
                    holding = 1'b1;
                    held_c  = c;
                    held_f  = flags;
                end else begin
                    holding = 1'b0;
                end
            end
        end
    end

    // Monitor for the bfloat16-like instance (out_ready2 held high).
    initial begin
        exp_t e2;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid2 && out_ready2) begin
                if (sb2_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result_bf: got c=%h, expected none", c2);
                end else begin
                    e2 = sb2_q.pop_front();
                    check("bf_result_c", 32'(c2), 32'(e2.c));
                    check("bf_result_flags", 32'(flags2), 32'(e2.f));
                    if (e2.lat) check("bf_latency", 32'(cyc - e2.acc), 32'd3);
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Stimulus sequence.
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = 16'h0000; b2 = 16'h0000; out_ready2 = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_c", 32'(c), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        check("reset_bf_in_ready", 32'(in_ready2), 32'd0);
        check("reset_bf_out_valid", 32'(out_valid2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic, rounding and special products, back to back, out_ready high.
        for (int i = 0; i < 9; i++) issue(0, va[i], vb[i], vc[i], vf[i], 1'b1, 1'b0);
        drain(1'b0);

        // Streaming with random backpressure.
        for (int i = 0; i < 8; i++) issue(0, va[i], vb[i], vc[i], vf[i], 1'b0, 1'b1);
        drain(1'b1);

        // Reset with three operations in flight; none of them may appear.
        issue(0, va[1], vb[1], vc[1], vf[1], 1'b1, 1'b0);
        issue(0, va[2], vb[2], vc[2], vf[2], 1'b1, 1'b0);
        issue(0, va[5], vb[5], vc[5], vf[5], 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_c", 32'(c), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        issue(0, 16'h3E00, 16'h3E00, 16'h3E00, 4'b0000, 1'b1, 1'b0);
        drain(1'b0);

        // bfloat16-like layout: 1.0 x 2.0 = 2.0, 1.5 x 1.5 = 2.25.
        issue(1, 16'h3F80, 16'h4000, 16'h4000, 4'b0000, 1'b1, 1'b0);
        issue(1, 16'h3FC0, 16'h3FC0, 16'h4010, 4'b0000, 1'b1, 1'b0);
        drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
